// File: rtl/wr_arb_pkg.sv
// ---------------------------------------------------------------------------
// wr_arb_pkg
// Shared definitions for the register-file write-port arbiter.
//   - Requester count and write-enable width
//   - MUX3S source-select encodings
//   - Special destination codes (R21, R22, broadcast)
//   - Arbiter state enum
//   - Small helpers for round-robin index stepping and source encoding
// ---------------------------------------------------------------------------
package wr_arb_pkg;

    localparam int NSRC  = 3;
    localparam int WEN_W = 20;

    // MUX3S encoding presented to the write decoder
    localparam logic [1:0] SRC_NONE  = 2'd0;
    localparam logic [1:0] SRC_MUX3D = 2'd1;
    localparam logic [1:0] SRC_RG2   = 2'd2;
    localparam logic [1:0] SRC_TR    = 2'd3;

    // Destination codes with non-linear mapping
    localparam logic [4:0] CODE_R21   = 5'd21;
    localparam logic [4:0] CODE_R22   = 5'd22;
    localparam logic [4:0] CODE_BCAST = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_BCAST = 2'd2
    } arb_state_e;

    // Next requester index in round-robin order, wrapping modulo NSRC.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Requester index 0/1/2 maps onto MUX3S 1/2/3.
    function automatic logic [1:0] src_code(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/wr_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// wr_port_arbiter_if
// Request-side bundle between the three destination-code sources and the
// write-port arbiter.
//   req_valid[2:0]      per-source request (bit0 MUX3D, bit1 RG2, bit2 TR)
//   req_dest_mux3d/rg2/tr  5-bit destination codes, stable while valid
//   req_ready[2:0]      per-source grant, at most one bit set
//
// Handshake: a source raises req_valid[i] with its code held stable; the
// transfer happens on the rising edge where req_valid[i] and req_ready[i]
// are both high. req_ready never depends on the destination codes.
// ---------------------------------------------------------------------------
interface wr_port_arbiter_if;
    import wr_arb_pkg::*;

    logic [NSRC-1:0] req_valid;
    logic [4:0]      req_dest_mux3d;
    logic [4:0]      req_dest_rg2;
    logic [4:0]      req_dest_tr;
    logic [NSRC-1:0] req_ready;

    modport master (
        output req_valid,
        output req_dest_mux3d,
        output req_dest_rg2,
        output req_dest_tr,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_dest_mux3d,
        input  req_dest_rg2,
        input  req_dest_tr,
        output req_ready
    );

endinterface

// File: rtl/wr_code_decode.sv
// ---------------------------------------------------------------------------
// wr_code_decode
// Combinational 5-bit destination code to write-enable decode.
//   code      in   5-bit destination code
//   onehot    out  WEN_W-bit enable (one-hot, or all ones for broadcast)
//   valid     out  code maps onto a register (includes broadcast)
//   is_bcast  out  code is the broadcast code 31
// Map: 1..18 -> bit code-1, 21 -> bit 18, 22 -> bit 19, 31 -> all ones,
// anything else is illegal and decodes to zero.
// ---------------------------------------------------------------------------
module wr_code_decode
    import wr_arb_pkg::*;
(
    input  logic [4:0]       code,
    output logic [WEN_W-1:0] onehot,
    output logic             valid,
    output logic             is_bcast
);

    localparam logic [WEN_W-1:0] ONE = {{(WEN_W-1){1'b0}}, 1'b1};

    always_comb begin
        onehot   = '0;
        valid    = 1'b0;
        is_bcast = 1'b0;
        if (code >= 5'd1 && code <= 5'd18) begin
            onehot = ONE << (code - 5'd1);
            valid  = 1'b1;
        end else if (code == CODE_R21) begin
            onehot = ONE << 18;
            valid  = 1'b1;
        end else if (code == CODE_R22) begin
            onehot = ONE << 19;
            valid  = 1'b1;
        end else if (code == CODE_BCAST) begin
            onehot   = '1;
            valid    = 1'b1;
            is_bcast = 1'b1;
        end
    end

endmodule

// File: rtl/wr_port_arbiter.sv
// ---------------------------------------------------------------------------
// wr_port_arbiter
// Sequencing controller for the register-file write port. Round-robin
// arbitration between MUX3D, RG2 and TR destination sources, registered
// MUX3S select, destination code and one-hot write enable, two-cycle
// broadcast for code 31, sticky illegal-code flag and datapath stall.
//   Clock        in   system clock, rising edge
//   Reset        in   asynchronous active-high reset
//   req_if       slave request bundle (valid / codes / ready)
//   stall        in   hold: no grants, outputs register zero, state frozen
//   err_clear    in   clears err_invalid (a same-cycle set wins)
//   MUX3S        out  registered source select (0 none, 1 MUX3D, 2 RG2, 3 TR)
//   dest_out     out  registered accepted code
//   wr_en        out  registered write enable
//   busy         out  state not IDLE or wr_en non-zero
//   err_invalid  out  sticky illegal-code flag
//   state_dbg    out  current FSM state
//   rr_ptr_dbg   out  round-robin search start index
// ---------------------------------------------------------------------------
module wr_port_arbiter
    import wr_arb_pkg::*;
(
    input  logic             Clock,
    input  logic             Reset,
    wr_port_arbiter_if.slave req_if,
    input  logic             stall,
    input  logic             err_clear,
    output logic [1:0]       MUX3S,
    output logic [4:0]       dest_out,
    output logic [WEN_W-1:0] wr_en,
    output logic             busy,
    output logic             err_invalid,
    output logic [1:0]       state_dbg,
    output logic [1:0]       rr_ptr_dbg
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_WRITE = ST_WRITE;
    localparam logic [1:0] S_BCAST = ST_BCAST;

    logic [1:0]       state_q,  state_d;
    logic [1:0]       ptr_q,    ptr_d;
    logic             tail_q,   tail_d;
    logic [1:0]       bc_src_q, bc_src_d;
    logic [1:0]       mux3s_q,  mux3s_d;
    logic [4:0]       dest_q,   dest_d;
    logic [WEN_W-1:0] wen_q,    wen_d;
    logic             err_q,    err_d;

    // ---------------- round-robin winner ----------------
    logic [1:0] cand0, cand1, cand2;
    logic [1:0] win_idx;
    logic       win_found;
    logic       grant_ok;
    logic       transfer;
    logic [4:0] win_dest;

    assign cand0 = ptr_q;
    assign cand1 = rr_next(ptr_q);
    assign cand2 = rr_next(cand1);

    always_comb begin
        win_idx   = 2'd0;
        win_found = 1'b0;
        if (req_if.req_valid[cand0]) begin
            win_idx   = cand0;
            win_found = 1'b1;
        end else if (req_if.req_valid[cand1]) begin
            win_idx   = cand1;
            win_found = 1'b1;
        end else if (req_if.req_valid[cand2]) begin
            win_idx   = cand2;
            win_found = 1'b1;
        end
    end

    // No grant while stalled, while the second broadcast cycle is pending
    // (BCAST) or while it is being presented (tail).
    assign grant_ok = !stall && (state_q != S_BCAST) && !tail_q;
    assign transfer = win_found && grant_ok;

    assign req_if.req_ready = transfer ? (3'b001 << win_idx) : 3'b000;

    always_comb begin
        case (win_idx)
            2'd0:    win_dest = req_if.req_dest_mux3d;
            2'd1:    win_dest = req_if.req_dest_rg2;
            default: win_dest = req_if.req_dest_tr;
        endcase
    end

    // ---------------- code decode ----------------
    logic [WEN_W-1:0] dec_onehot;
    logic             dec_valid;
    logic             dec_bcast;

    wr_code_decode u_decode (
        .code     (win_dest),
        .onehot   (dec_onehot),
        .valid    (dec_valid),
        .is_bcast (dec_bcast)
    );

    // ---------------- FSM / output next-state ----------------
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        tail_d   = tail_q;
        bc_src_d = bc_src_q;
        mux3s_d  = SRC_NONE;
        dest_d   = '0;
        wen_d    = '0;
        err_d    = err_q;

        if (err_clear) begin
            err_d = 1'b0;
        end

        if (stall) begin
            // Outputs drop to zero; state, pointer and the saved broadcast
            // source hold. A tail write already went out, so nothing of it
            // needs resuming.
            tail_d = 1'b0;
        end else if (state_q == S_BCAST) begin
            // Second broadcast cycle, re-presenting the saved source.
            wen_d   = '1;
            mux3s_d = bc_src_q;
            dest_d  = CODE_BCAST;
            state_d = S_WRITE;
            tail_d  = 1'b1;
        end else if (transfer) begin
            ptr_d  = rr_next(win_idx);
            tail_d = 1'b0;
            if (dec_bcast) begin
                wen_d    = '1;
                mux3s_d  = src_code(win_idx);
                dest_d   = CODE_BCAST;
                bc_src_d = src_code(win_idx);
                state_d  = S_BCAST;
            end else if (dec_valid) begin
                wen_d   = dec_onehot;
                mux3s_d = src_code(win_idx);
                dest_d  = win_dest;
                state_d = S_WRITE;
            end else begin
                // Illegal code: handshake completes, nothing is written.
                state_d = S_IDLE;
                err_d   = 1'b1;
            end
        end else begin
            state_d = S_IDLE;
            tail_d  = 1'b0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= 2'd0;
            tail_q   <= 1'b0;
            bc_src_q <= SRC_NONE;
            mux3s_q  <= SRC_NONE;
            dest_q   <= '0;
            wen_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            tail_q   <= tail_d;
            bc_src_q <= bc_src_d;
            mux3s_q  <= mux3s_d;
            dest_q   <= dest_d;
            wen_q    <= wen_d;
            err_q    <= err_d;
        end
    end

    assign MUX3S       = mux3s_q;
    assign dest_out    = dest_q;
    assign wr_en       = wen_q;
    assign err_invalid = err_q;
    assign busy        = (state_q != S_IDLE) || (|wen_q);
    assign state_dbg   = state_q;
    assign rr_ptr_dbg  = ptr_q;

endmodule

// File: tb/tb_wr_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wr_port_arbiter
// Directed bench for wr_port_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are sampled there too, away from the active edge.
// ---------------------------------------------------------------------------
module tb_wr_port_arbiter;
    import wr_arb_pkg::*;

    logic             Clock;
    logic             Reset;
    logic             stall;
    logic             err_clear;
    logic [1:0]       MUX3S;
    logic [4:0]       dest_out;
    logic [WEN_W-1:0] wr_en;
    logic             busy;
    logic             err_invalid;
    logic [1:0]       state_dbg;
    logic [1:0]       rr_ptr_dbg;

    wr_port_arbiter_if rif ();

    wr_port_arbiter dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .req_if      (rif),
        .stall       (stall),
        .err_clear   (err_clear),
        .MUX3S       (MUX3S),
        .dest_out    (dest_out),
        .wr_en       (wr_en),
        .busy        (busy),
        .err_invalid (err_invalid),
        .state_dbg   (state_dbg),
        .rr_ptr_dbg  (rr_ptr_dbg)
    );

    // ---------------- clock ----------------
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [WEN_W-1:0] exp_q[$];
    logic [1:0]       exp_sel_q[$];
    logic [2:0]       exp_rdy_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic [2:0] v, input logic [4:0] d0,
                         input logic [4:0] d1, input logic [4:0] d2);
        rif.req_valid      = v;
        rif.req_dest_mux3d = d0;
        rif.req_dest_rg2   = d1;
        rif.req_dest_tr    = d2;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        drive(3'b000, 5'd0, 5'd0, 5'd0);
        step();
        Reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        Reset     = 1'b1;
        stall     = 1'b0;
        err_clear = 1'b0;
        drive(3'b000, 5'd0, 5'd0, 5'd0);
        repeat (2) @(posedge Clock);
        #1;
        check("rst_mux3s", 32'(MUX3S), 32'd0);
        check("rst_dest", 32'(dest_out), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_invalid), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_ptr", 32'(rr_ptr_dbg), 32'd0);
        Reset = 1'b0;

        // ---- single RG2 write, code 5 ----
        drive(3'b010, 5'd0, 5'd5, 5'd0);
        #1;
        check("t1_ready", 32'(rif.req_ready), 32'h2);
        step();
        drive(3'b000, 5'd0, 5'd0, 5'd0);
        check("t1_mux3s", 32'(MUX3S), 32'd2);
        check("t1_wr_en", 32'(wr_en), 32'h00010);
        check("t1_dest", 32'(dest_out), 32'd5);
        check("t1_busy", 32'(busy), 32'd1);
        step();
        check("t1_wr_en_off", 32'(wr_en), 32'd0);
        check("t1_busy_off", 32'(busy), 32'd0);

        // ---- all three valid, round-robin from MUX3D ----
        do_reset();
        drive(3'b111, 5'd1, 5'd2, 5'd3);
        #1;
        check("t2_ready0", 32'(rif.req_ready), 32'h1);
        exp_q     = '{20'h00001, 20'h00002, 20'h00004, 20'h00001};
        exp_sel_q = '{2'd1, 2'd2, 2'd3, 2'd1};
        exp_rdy_q = '{3'b010, 3'b100, 3'b001, 3'b010};
        for (int i = 0; i < 4; i++) begin
            step();
            check("t2_wr_en", 32'(wr_en), 32'(exp_q.pop_front()));
            check("t2_mux3s", 32'(MUX3S), 32'(exp_sel_q.pop_front()));
            check("t2_ready", 32'(rif.req_ready), 32'(exp_rdy_q.pop_front()));
        end
        drive(3'b000, 5'd0, 5'd0, 5'd0);
        step();
        check("t2_idle", 32'(wr_en), 32'd0);

        // ---- TR broadcast with MUX3D pending (pointer at RG2) ----
        drive(3'b101, 5'd7, 5'd0, 5'd31);
        #1;
        check("t3_ready_tr", 32'(rif.req_ready), 32'h4);
        step();
        drive(3'b001, 5'd7, 5'd0, 5'd0);
        check("t3_bc1_wr_en", 32'(wr_en), 32'hFFFFF);
        check("t3_bc1_mux3s", 32'(MUX3S), 32'd3);
        check("t3_bc1_ready", 32'(rif.req_ready), 32'h0);
        step();
        check("t3_bc2_wr_en", 32'(wr_en), 32'hFFFFF);
        check("t3_bc2_dest", 32'(dest_out), 32'd31);
        check("t3_bc2_ready", 32'(rif.req_ready), 32'h0);
        step();
        check("t3_gap_wr_en", 32'(wr_en), 32'd0);
        check("t3_ready_m3d", 32'(rif.req_ready), 32'h1);
        step();
        drive(3'b000, 5'd0, 5'd0, 5'd0);
        check("t3_m3d_wr_en", 32'(wr_en), 32'h00040);
        check("t3_m3d_mux3s", 32'(MUX3S), 32'd1);

        // ---- illegal code 20 from MUX3D ----
        drive(3'b001, 5'd20, 5'd0, 5'd0);
        #1;
        check("t4_ready", 32'(rif.req_ready), 32'h1);
        step();
        drive(3'b000, 5'd0, 5'd0, 5'd0);
        check("t4_wr_en", 32'(wr_en), 32'd0);
        check("t4_mux3s", 32'(MUX3S), 32'd0);
        check("t4_err", 32'(err_invalid), 32'd1);
        step();
        check("t4_err_held", 32'(err_invalid), 32'd1);
        drive(3'b001, 5'd0, 5'd0, 5'd0);
        err_clear = 1'b1;
        step();
        drive(3'b000, 5'd0, 5'd0, 5'd0);
        check("t4_set_wins", 32'(err_invalid), 32'd1);
        step();
        err_clear = 1'b0;
        check("t4_cleared", 32'(err_invalid), 32'd0);

        // ---- stall during pending broadcast second cycle ----
        do_reset();
        drive(3'b001, 5'd31, 5'd0, 5'd0);
        step();
        drive(3'b010, 5'd0, 5'd21, 5'd0);
        stall = 1'b1;
        check("t5_bc1_wr_en", 32'(wr_en), 32'hFFFFF);
        #1;
        check("t5_stall_ready", 32'(rif.req_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_stall_wr_en", 32'(wr_en), 32'd0);
            check("t5_stall_mux3s", 32'(MUX3S), 32'd0);
        end
        stall = 1'b0;
        #1;
        check("t5_pend_ready", 32'(rif.req_ready), 32'h0);
        step();
        check("t5_bc2_wr_en", 32'(wr_en), 32'hFFFFF);
        check("t5_bc2_mux3s", 32'(MUX3S), 32'd1);
        check("t5_bc2_dest", 32'(dest_out), 32'd31);
        check("t5_bc2_ready", 32'(rif.req_ready), 32'h0);
        step();
        check("t5_gap_wr_en", 32'(wr_en), 32'd0);
        check("t5_ready_rg2", 32'(rif.req_ready), 32'h2);
        step();
        drive(3'b000, 5'd0, 5'd0, 5'd0);
        check("t5_r21_wr_en", 32'(wr_en), 32'h40000);
        check("t5_r21_mux3s", 32'(MUX3S), 32'd2);

        // ---- reset mid-broadcast (pointer at TR) ----
        drive(3'b100, 5'd0, 5'd0, 5'd31);
        step();
        drive(3'b000, 5'd0, 5'd0, 5'd0);
        check("t6_bc1_wr_en", 32'(wr_en), 32'hFFFFF);
        #2;
        Reset = 1'b1;
        #1;
        check("t6_rst_wr_en", 32'(wr_en), 32'd0);
        check("t6_rst_mux3s", 32'(MUX3S), 32'd0);
        check("t6_rst_dest", 32'(dest_out), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        #1;
        Reset = 1'b0;
        step();
        check("t6_no_write", 32'(wr_en), 32'd0);
        drive(3'b111, 5'd22, 5'd9, 5'd10);
        #1;
        check("t6_ready_m3d", 32'(rif.req_ready), 32'h1);
        step();
        drive(3'b000, 5'd0, 5'd0, 5'd0);
        check("t6_r22_wr_en", 32'(wr_en), 32'h80000);
        check("t6_r22_mux3s", 32'(MUX3S), 32'd1);
        check("t6_r22_dest", 32'(dest_out), 32'd22);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
